// File: rtl/down_counter_pkg.sv
// Shared constants and helpers for the down counter.
// all_ones() builds the default reset value for any width up to 64 bits.
package down_counter_pkg;

    localparam int DOWN_CNT_DEFAULT_W = 4;
    localparam int DOWN_CNT_MAX_W     = 64;

    function automatic logic [DOWN_CNT_MAX_W-1:0] all_ones(input int width);
        logic [DOWN_CNT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < DOWN_CNT_MAX_W; i++) begin
            if (i < width) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/down_counter.sv
// N-bit free-running down counter with count enable, zero decode and a
// registered one-cycle wrap pulse on each 0 -> all-ones transition.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int                        N       = DOWN_CNT_DEFAULT_W,
    parameter logic [DOWN_CNT_MAX_W-1:0] RST_VAL = all_ones(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    output logic [N-1:0] count,
    output logic         zero,
    output logic         wrap
);

    // Wider reset values are deliberately cut down to the counter width.
    localparam logic [N-1:0] RST_CNT = RST_VAL[N-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= RST_CNT;
        else if (enable)
            count <= count - N'(1);
    end

    // Sampled against the pre-edge count, so it lands together with all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wrap <= 1'b0;
        else
            wrap <= enable && (count == '0);
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench: three counter configurations against an arithmetic
// reference model, with directed scenarios followed by random enable/reset.
module tb_down_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en4, en1, en8;
    logic [3:0] c4;
    logic [0:0] c1;
    logic [7:0] c8;
    logic       z4, z1, z8;
    logic       w4, w1, w8;

    int nchk  = 0;
    int nfail = 0;

    // reference state: integer counts and expected wrap flags
    int m4, m1, m8;
    bit x4, x1, x8;

    down_counter u4 (.clk(clk), .rst(rst), .enable(en4), .count(c4), .zero(z4), .wrap(w4));
    down_counter #(.N(1)) u1 (.clk(clk), .rst(rst), .enable(en1), .count(c1), .zero(z1), .wrap(w1));
    down_counter #(.N(8), .RST_VAL(64'h03)) u8 (.clk(clk), .rst(rst), .enable(en8), .count(c8), .zero(z8), .wrap(w8));

    always #5 clk = ~clk;

    function automatic int dec(input int m, input int modulus);
        return (m == 0) ? modulus - 1 : m - 1;
    endfunction

    task automatic model_reset();
        m4 = 15; m1 = 1; m8 = 3;
        x4 = 0;  x1 = 0; x8 = 0;
    endtask

    // Advance one rising edge, update the model from the sampled inputs,
    // then settle 1 ns so outputs are read away from the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            x4 = en4 && (m4 == 0); if (en4) m4 = dec(m4, 16);
            x1 = en1 && (m1 == 0); if (en1) m1 = dec(m1, 2);
            x8 = en8 && (m8 == 0); if (en8) m8 = dec(m8, 256);
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en4 = 0; en1 = 0; en8 = 0;
        rst = 1'b1;
        model_reset();
        #10;
        nchk++; if (c4 !== 4'hF || w4 !== 1'b0 || z4 !== 1'b0) begin
            nfail++; $display("FAIL reset_n4: count=%h wrap=%b zero=%b want count=f wrap=0 zero=0", c4, w4, z4);
        end
        nchk++; if (c1 !== 1'b1 || c8 !== 8'h03) begin
            nfail++; $display("FAIL reset_params: c1=%h c8=%h want c1=1 c8=03", c1, c8);
        end
        tick();
        rst = 1'b0;
        tick();
        nchk++; if (c4 !== 4'hF || w4 !== 1'b0) begin
            nfail++; $display("FAIL reset_idle_hold: count=%h wrap=%b want f/0", c4, w4);
        end
    endtask

    task automatic test_count_run();
        en4 = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            nchk++; if (c4 !== 4'(m4) || w4 !== x4 || z4 !== (m4 == 0)) begin
                nfail++; $display("FAIL count_run[%0d]: count=%h wrap=%b zero=%b want %h/%b/%b",
                                  i, c4, w4, z4, 4'(m4), x4, m4 == 0);
            end
        end
        nchk++; if (c4 !== 4'hB) begin
            nfail++; $display("FAIL count_run_final: count=%h want b", c4);
        end
        en4 = 0;
        tick(); tick();
        nchk++; if (c4 !== 4'hB || w4 !== 1'b0) begin
            nfail++; $display("FAIL count_run_hold: count=%h wrap=%b want b/0", c4, w4);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        en4 = 1;
        repeat (15) tick();
        nchk++; if (c4 !== 4'h0 || z4 !== 1'b1 || w4 !== 1'b0) begin
            nfail++; $display("FAIL wrap_at_zero: count=%h zero=%b wrap=%b want 0/1/0", c4, z4, w4);
        end
        tick();
        nchk++; if (c4 !== 4'hF || w4 !== 1'b1 || z4 !== 1'b0) begin
            nfail++; $display("FAIL wrap_pulse: count=%h wrap=%b zero=%b want f/1/0", c4, w4, z4);
        end
        tick();
        nchk++; if (c4 !== 4'hE || w4 !== 1'b0) begin
            nfail++; $display("FAIL wrap_one_cycle: count=%h wrap=%b want e/0", c4, w4);
        end
        en4 = 0;
    endtask

    task automatic test_hold();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            bit en_now;
            en_now = (i % 4) < 2;
            en4 = en_now;
            tick();
            nchk++; if (c4 !== 4'(m4) || w4 !== x4) begin
                nfail++; $display("FAIL hold[%0d]: count=%h wrap=%b want %h/%b", i, c4, w4, 4'(m4), x4);
            end
            if (!en_now) begin
                nchk++; if (w4 !== 1'b0) begin
                    nfail++; $display("FAIL hold_wrap_low[%0d]: wrap=%b want 0", i, w4);
                end
            end
        end
        en4 = 0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        en4 = 1;
        repeat (8) tick();
        nchk++; if (c4 !== 4'h7) begin
            nfail++; $display("FAIL async_setup: count=%h want 7", c4);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        nchk++; if (c4 !== 4'hF || w4 !== 1'b0) begin
            nfail++; $display("FAIL async_mid_cycle: count=%h wrap=%b want f/0", c4, w4);
        end
        tick();
        nchk++; if (c4 !== 4'hF) begin
            nfail++; $display("FAIL async_reset_wins: count=%h want f", c4);
        end
        rst = 1'b0;
        tick();
        nchk++; if (c4 !== 4'hE) begin
            nfail++; $display("FAIL async_release: count=%h want e", c4);
        end
        en4 = 0;
    endtask

    task automatic test_params();
        int  exp1[4] = '{0, 1, 0, 1};
        bit  wr1[4]  = '{0, 1, 0, 1};
        int  exp8[4] = '{2, 1, 0, 255};
        bit  wr8[4]  = '{0, 0, 0, 1};
        apply_reset();
        en1 = 1; en8 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nchk++; if (c1 !== 1'(exp1[i]) || w1 !== wr1[i] || z1 !== (exp1[i] == 0)) begin
                nfail++; $display("FAIL params_n1[%0d]: count=%h wrap=%b zero=%b want %0d/%b", i, c1, w1, z1, exp1[i], wr1[i]);
            end
            nchk++; if (c8 !== 8'(exp8[i]) || w8 !== wr8[i] || z8 !== (exp8[i] == 0)) begin
                nfail++; $display("FAIL params_n8[%0d]: count=%h wrap=%b zero=%b want %h/%b", i, c8, w8, z8, 8'(exp8[i]), wr8[i]);
            end
        end
        en1 = 0; en8 = 0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            en4 = 1'($urandom);
            en1 = 1'($urandom);
            en8 = ($urandom_range(3) != 0);
            rst = ($urandom_range(39) == 0);
            if (rst) model_reset();
            tick();
            nchk++; if (c4 !== 4'(m4) || w4 !== x4 || z4 !== (m4 == 0)) begin
                nfail++; $display("FAIL rand_n4[%0d]: count=%h wrap=%b zero=%b want %h/%b/%b", i, c4, w4, z4, 4'(m4), x4, m4 == 0);
            end
            nchk++; if (c1 !== 1'(m1) || w1 !== x1 || z1 !== (m1 == 0)) begin
                nfail++; $display("FAIL rand_n1[%0d]: count=%h wrap=%b zero=%b want %h/%b/%b", i, c1, w1, z1, 1'(m1), x1, m1 == 0);
            end
            nchk++; if (c8 !== 8'(m8) || w8 !== x8 || z8 !== (m8 == 0)) begin
                nfail++; $display("FAIL rand_n8[%0d]: count=%h wrap=%b zero=%b want %h/%b/%b", i, c8, w8, z8, 8'(m8), x8, m8 == 0);
            end
        end
        rst = 1'b0;
        en4 = 0; en1 = 0; en8 = 0;
    endtask

    initial begin
        test_reset();
        test_count_run();
        test_wrap();
        test_hold();
        test_async_reset();
        test_params();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
